// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential restoring divider, one quotient bit per clock
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX sign-correction state).
module div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t state, state_next;

  // dvd shifts dividend bits out of the MSB while quotient bits enter at the LSB
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH-1:0] dvd_next, rem_next;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    cnt;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    trial    = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
    rem_next = trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
`ifdef DIV_SIGNED_EN
      CALC: if (cnt == LAST) state_next = FIX;
      FIX:  state_next = DONE;
`else
      CALC: if (cnt == LAST) state_next = DONE;
`endif
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= mag_a;
            dvs <= mag_b;
            rem <= '0;
            cnt <= '0;
`ifdef DIV_SIGNED_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          dvd <= dvd_next;
          rem <= rem_next;
          cnt <= cnt + 1'b1;
`ifndef DIV_SIGNED_EN
          if (cnt == LAST) begin
            quotient  <= dvd_next;
            remainder <= rem_next;
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          quotient  <= neg_q ? -dvd : dvd;
          remainder <= neg_r ? -rem : rem;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - table-driven, scoreboarded bench for div_unit
// Signed vectors are used when DIV_SIGNED_EN is defined.
module tb_div_unit;
  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           exp_edge;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Results are compared in the cycle before the take edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got q=%0d r=%0d, required no output", quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                        input int exp_edge);
    int   n;
    exp_t e;
    chk("in_ready_idle", in_ready, 1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    wait_valid(n);
    chk("result_edge", n, exp_edge);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_q", quotient, q);
      chk("hold_r", remainder, r);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int           n;
    int           seen;
    exp_t         e;
    logic [W-1:0] ra, rb;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{8'hF9, 8'h02, 0, 8'hFD, 8'hFF, 1'b0, LAT});
    vecs.push_back('{8'h80, 8'hFF, 0, 8'h80, 8'h00, 1'b0, LAT});
    vecs.push_back('{8'h07, 8'hFE, 1, 8'hFD, 8'h01, 1'b0, LAT});
    vecs.push_back('{8'h80, 8'h00, 0, 8'hFF, 8'h80, 1'b1, 0});
    vecs.push_back('{8'h7F, 8'h80, 2, 8'h00, 8'h7F, 1'b0, LAT});
`else
    vecs.push_back('{8'd100, 8'd7,   0, 8'd14,  8'd2,   1'b0, LAT});
    vecs.push_back('{8'd200, 8'd0,   0, 8'd255, 8'd200, 1'b1, 0});
    vecs.push_back('{8'd255, 8'd255, 1, 8'd1,   8'd0,   1'b0, LAT});
    vecs.push_back('{8'd128, 8'd16,  2, 8'd8,   8'd0,   1'b0, LAT});
    vecs.push_back('{8'd254, 8'd15,  0, 8'd16,  8'd14,  1'b0, LAT});
    vecs.push_back('{8'd1,   8'd255, 0, 8'd0,   8'd1,   1'b0, LAT});
    vecs.push_back('{8'd0,   8'd5,   0, 8'd0,   8'd0,   1'b0, LAT});
    vecs.push_back('{8'd0,   8'd0,   3, 8'd255, 8'd0,   1'b1, 0});
    vecs.push_back('{8'd7,   8'd7,   0, 8'd1,   8'd0,   1'b0, LAT});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].exp_edge);

`ifndef DIV_SIGNED_EN
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      if (rb == '0) run_op(ra, rb, 0, 8'd255, ra, 1'b1, 0);
      else          run_op(ra, rb, $urandom_range(0, 2), ra / rb, ra % rb, 1'b0, LAT);
    end
`endif

    // 255/1 held for 5 cycles while 5/9 is already requested
    dividend = 8'd255; divisor = 8'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    e.q = (LAT == W) ? 8'd255 : 8'hFF; e.r = 8'd0; e.dbz = 1'b0;
    sb.push_back(e);
    dividend = 8'd5; divisor = 8'd9;
    wait_valid(n);
    chk("held_edge", n, LAT);
    for (int i = 0; i < 5; i++) begin
      chk("held_in_ready", in_ready, 0);
      chk("held_valid", out_valid, 1);
      chk("held_q", quotient, 8'd255);
      chk("held_r", remainder, 8'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("second_idle", in_ready, 1);
    e.q = 8'd0; e.r = 8'd5; e.dbz = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second_accept", in_ready, 0);
    wait_valid(n);
    chk("second_edge", n, LAT);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during step 4 of 77/3 must abort with no result
    dividend = 8'd77; divisor = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    out_ready = 1'b0;
    run_op(8'd9, 8'd3, 0, 8'd3, 8'd0, 1'b0, LAT);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential unsigned integer divider that sits beside the ALU as the inverse of its multiply path. It accepts one dividend/divisor pair via a valid/ready handshake and computes quotient and remainder with a restoring algorithm, one quotient bit per clock. It presents the result on a held valid/ready output port. It is used for the core's divide/modulo operations, which the single-cycle ALU does not provide.

## Interface
- WIDTH, 8, operand and result width in bits; the iteration count equals WIDTH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  divider can accept; high only in IDLE
- dividend  input  WIDTH  numerator; sampled at accept
- divisor  input  WIDTH  denominator; sampled at accept
- out_valid  output  1  result present; held until taken
- out_ready  input  1  consumer takes result
- quotient  output  WIDTH  dividend / divisor
- remainder  output  WIDTH  dividend % divisor
- div_by_zero  output  1  result came from a zero divisor; valid with out_valid

## Operation
- The reset scheme is fixed: one clock, reset asynchronous and active-low.
- State machine with three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready at a rising edge.
  - On accept, latch the operands, clear the partial remainder, and set the step counter to 0.
  - Nonzero divisor: go to CALC.
  - Zero divisor: go directly to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- CALC, one restoring step per edge:
  - The WIDTH+1-bit trial is {partial remainder, next dividend MSB} minus divisor.
  - If the trial is non-negative, keep the difference and shift in quotient bit 1.
  - Otherwise, keep the shifted value and shift in quotient bit 0.
  - After step WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are stable.
  - On out_valid && out_ready, go to IDLE.
- in_valid while not in IDLE is ignored. No queuing; the requester must hold its request.
- Outputs are registered. No output changes while out_valid=1.
- Arithmetic rules:
  - All internal arithmetic uses WIDTH+1 bits, so there is no carry loss.
  - Result identity: remainder < divisor and quotient*divisor + remainder = dividend, for every divisor ≠ 0.
- Reset:
  - Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Reset asserted mid-CALC or mid-DONE aborts the operation. No out_valid is produced for the aborted request.

## Timing
- Accept edge is E0.
- Nonzero divisor: steps occur at E1..E_WIDTH, and out_valid rises after E_WIDTH. Latency is WIDTH cycles (8 at default).
- Zero divisor: out_valid rises after E0. Latency is 1 cycle.
- out_ready already high when out_valid rises: DONE lasts exactly 1 cycle. in_ready returns in the following cycle.
- Best-case throughput is one operation per WIDTH+2 cycles.
- out_ready low: out_valid and the data hold indefinitely.

## Configuration
- DIV_SIGNED_EN defined:
  - Operands and results are two's complement.
  - Magnitudes are divided as above, then one extra FIX state follows CALC to apply signs.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Nonzero-divisor latency becomes WIDTH+1.
  - Overflow case most-negative / −1 gives quotient=most-negative, remainder=0, div_by_zero=0.
  - Zero divisor gives quotient={WIDTH{1}}, remainder=dividend.
- DIV_SIGNED_EN undefined: unsigned only, no FIX state, latency as in Timing.

## Test plan
- 100/7 with out_ready=1 -> in_ready drops after accept; out_valid after 8 cycles; quotient=14, remainder=2, div_by_zero=0.
- 200/0 -> out_valid 1 cycle after accept; quotient=255, remainder=200, div_by_zero=1.
- 255/1, then 5/9, with out_ready low for 5 cycles on the first -> first result 255 r0 held stable for 5 cycles, no second accept meanwhile; second result 0 r5.
- rst_n low at step 4 of 77/3 -> immediate IDLE, all outputs 0, in_ready=1; a new request 9/3 then gives 3 r0.
- With DIV_SIGNED_EN: −7/2 -> quotient=−3 (8'hFD), remainder=−1 (8'hFF), latency 9; −128/−1 -> 8'h80 r0.
